// File: rtl/ifmap_pkg.sv
// Shared constants and FSM state encoding for the ifmap stream reader.
package ifmap_pkg;

  localparam int IFMAP_W      = 28;
  localparam int IFMAP_H      = 28;
  localparam int IFMAP_PIXELS = 784;
  localparam int IFMAP_ADDR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BRAM = 2'd1,
    ST_STREAM    = 2'd2,
    ST_DRAIN     = 2'd3
  } ifmap_state_e;

endpackage

// File: rtl/ifmap_skid_fifo.sv
// Two-entry FIFO holding tagged pixels between the BRAM read port and the
// output stream. The caller never writes when full nor reads when empty.
module ifmap_skid_fifo #(
  parameter int W = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         wr_ptr;
  logic         rd_ptr;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign rd_data = rd_ptr ? mem1 : mem0;

  // Storage, pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr_en) begin
        if (wr_ptr) mem1 <= wr_data;
        else        mem0 <= wr_data;
        wr_ptr <= ~wr_ptr;
      end
      if (rd_en) rd_ptr <= ~rd_ptr;
      if (wr_en && !rd_en)      count <= count + 2'd1;
      else if (!wr_en && rd_en) count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/ifmap_stream_reader.sv
// Reads one full ifmap frame out of the BRAM per start pulse and emits it
// as a raster-order pixel stream tagged with row/column position.
//
// Stream handshake: a beat transfers only in a cycle where pix_valid and
// pix_ready are both 1. Once pix_valid rises it stays high, and every pix_*
// output holds its value, until that beat transfers.
module ifmap_stream_reader
  import ifmap_pkg::*;
#(
  parameter int IMG_W  = IFMAP_W,
  parameter int IMG_H  = IFMAP_H,
  parameter int ADDR_W = IFMAP_ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifmap_bram_ready,
  input  logic              start,
  output logic [ADDR_W-1:0] ifmap_read_addr,
  input  logic [DATA_W-1:0] ifmap_bram_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [4:0]        pix_row,
  output logic [4:0]        pix_col,
  output logic              pix_last_col,
  output logic              pix_last_frame,
  output logic              busy,
  output logic              done,
  output ifmap_state_e      dbg_state,
  output logic [1:0]        dbg_fifo_count
);

  localparam int PIXELS  = IMG_W * IMG_H;
  localparam int ENTRY_W = DATA_W + 12;

  ifmap_state_e state, state_nxt;

  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  last_addr;
  logic [4:0]         rd_row;
  logic [4:0]         rd_col;
  logic               infl;
  logic [4:0]         infl_row;
  logic [4:0]         infl_col;
  logic               infl_lc;
  logic               infl_lf;
  logic               done_q;

  logic               pop;
  logic [2:0]         occ;
  logic               issue;
  logic               last_issue;

  logic               fifo_wr;
  logic               fifo_rd;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [1:0]         fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  // Pixels held or on their way = FIFO entries + the read in flight; a new
  // read may go out only if at most one slot stays taken after this pop.
  assign pop        = pix_valid & pix_ready;
  assign occ        = {1'b0, fifo_count} + {2'b0, infl} - {2'b0, pop};
  assign issue      = (state == ST_STREAM) && (occ < 3'd2);
  assign last_issue = issue && (rd_ptr == ADDR_W'(PIXELS - 1));

  // The address port shows the read being issued, else the last one issued.
  assign ifmap_read_addr = issue ? rd_ptr : last_addr;

  // An arriving pixel bypasses the empty FIFO; it is stored unless it
  // transfers in the same cycle.
  assign fifo_wdata = {ifmap_bram_out, infl_row, infl_col, infl_lc, infl_lf};
  assign fifo_wr    = infl & ~fifo_full & ~(fifo_empty & pop);
  assign fifo_rd    = pop & ~fifo_empty;
  assign pix_valid  = ~fifo_empty | infl;

  assign busy           = (state != ST_IDLE) | done_q;
  assign done           = done_q;
  assign dbg_state      = state;
  assign dbg_fifo_count = fifo_count;

  ifmap_skid_fifo #(.W(ENTRY_W)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Output beat selection: FIFO head first, then the bypassed arrival, else zeros.
  always_comb begin
    {pix_data, pix_row, pix_col, pix_last_col, pix_last_frame} = '0;
    if (!fifo_empty) begin
      {pix_data, pix_row, pix_col, pix_last_col, pix_last_frame} = fifo_rdata;
    end else if (infl) begin
      {pix_data, pix_row, pix_col, pix_last_col, pix_last_frame} = fifo_wdata;
    end
  end

  // FSM next-state: start is honoured only in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ifmap_bram_ready ? ST_STREAM : ST_WAIT_BRAM;
      ST_WAIT_BRAM: if (ifmap_bram_ready) state_nxt = ST_STREAM;
      ST_STREAM:    if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN:     if (pop && pix_last_frame) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // State register and the completion pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == ST_DRAIN) && pop && pix_last_frame;
    end
  end

  // Read pointer with row/column counters; all rewind when heading to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      last_addr <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
    end else if (state_nxt == ST_IDLE) begin
      rd_ptr    <= '0;
      last_addr <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
    end else if (issue) begin
      last_addr <= rd_ptr;
      rd_ptr    <= rd_ptr + 1'b1;
      if (rd_col == 5'(IMG_W - 1)) begin
        rd_col <= '0;
        rd_row <= rd_row + 5'd1;
      end else begin
        rd_col <= rd_col + 5'd1;
      end
    end
  end

  // Tags of the read in flight, aligned with the BRAM data next cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      infl     <= 1'b0;
      infl_row <= '0;
      infl_col <= '0;
      infl_lc  <= 1'b0;
      infl_lf  <= 1'b0;
    end else begin
      infl <= issue;
      if (issue) begin
        infl_row <= rd_row;
        infl_col <= rd_col;
        infl_lc  <= (rd_col == 5'(IMG_W - 1));
        infl_lf  <= (rd_ptr == ADDR_W'(PIXELS - 1));
      end
    end
  end

endmodule

// File: tb/tb_ifmap_stream_reader.sv
// Bench for ifmap_stream_reader: directed frame passes against a BRAM model
// holding mem[a] = a[7:0], with a queue-based scoreboard on the pixel stream.
module tb_ifmap_stream_reader;
  import ifmap_pkg::*;

  localparam int W    = 28;
  localparam int NPIX = 784;

  // ---------------- clock / reset / DUT ----------------
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         ifmap_bram_ready = 1'b0;
  logic         start = 1'b0;
  logic         pix_ready = 1'b0;
  logic [9:0]   ifmap_read_addr;
  logic [7:0]   ifmap_bram_out = 8'd0;
  logic         pix_valid;
  logic [7:0]   pix_data;
  logic [4:0]   pix_row;
  logic [4:0]   pix_col;
  logic         pix_last_col;
  logic         pix_last_frame;
  logic         busy;
  logic         done;
  ifmap_state_e dbg_state;
  logic [1:0]   dbg_fifo_count;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  ifmap_stream_reader dut (
    .clock            (clock),
    .reset            (reset),
    .ifmap_bram_ready (ifmap_bram_ready),
    .start            (start),
    .ifmap_read_addr  (ifmap_read_addr),
    .ifmap_bram_out   (ifmap_bram_out),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .pix_data         (pix_data),
    .pix_row          (pix_row),
    .pix_col          (pix_col),
    .pix_last_col     (pix_last_col),
    .pix_last_frame   (pix_last_frame),
    .busy             (busy),
    .done             (done),
    .dbg_state        (dbg_state),
    .dbg_fifo_count   (dbg_fifo_count)
  );

  // BRAM model: synchronous read, data one cycle after the address.
  logic [7:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
  always @(posedge clock) ifmap_bram_out <= mem[ifmap_read_addr];

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int beats = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int done_cnt = 0;
  int done_cyc = -1;
  int s_cyc = 0;
  logic rnd_ready = 1'b0;
  logic ready_val = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // pix_ready driver: held value or 50% random, changed after each active edge.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Monitor: compares every transferred beat and watches stalls and done.
  initial begin
    logic        prev_stall;
    logic [19:0] prev_beat;
    logic [19:0] cur;
    logic [19:0] e;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_stall = 1'b0;
      end else begin
        cur = {pix_data, pix_row, pix_col, pix_last_col, pix_last_frame};
        check("fifo_count_le2", {31'b0, (dbg_fifo_count <= 2'd2)}, 32'd1);
        if (prev_stall) begin
          check("stall_valid_hold", {31'b0, pix_valid}, 32'd1);
          check("stall_beat_hold", 32'(cur), 32'(prev_beat));
        end
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat (t=%0t)", cur, $time);
          end else begin
            e = exp_q.pop_front();
            check("beat", 32'(cur), 32'(e));
          end
          if (beats == 0) first_cyc = cyc;
          if (pix_last_frame) last_cyc = cyc;
          beats++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_stall = pix_valid && !pix_ready;
        prev_beat  = cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame();
    logic [19:0] e;
    for (int a = 0; a < NPIX; a++) begin
      e = {8'(a % 256), 5'(a / W), 5'(a % W), 1'((a % W) == W - 1), 1'(a == NPIX - 1)};
      exp_q.push_back(e);
    end
  endtask

  // Pulses start for one cycle (cycle 0); returns early in cycle 1.
  task automatic start_frame();
    beats     = 0;
    first_cyc = -1;
    last_cyc  = -1;
    push_frame();
    @(posedge clock);
    #1;
    start = 1'b1;
    s_cyc = cyc;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clock);
      #2;
      k++;
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_done_timeout: got no done in %0d cycles expected done", name, budget);
    end
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (beats < n && k < budget) begin
      @(negedge clock);
      #2;
      k++;
    end
    if (beats < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_beat_timeout: got %0d beats expected %0d", name, beats, n);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_addr"}, 32'(ifmap_read_addr), 0);
    check({name, "_valid"}, 32'(pix_valid), 0);
    check({name, "_data"}, 32'(pix_data), 0);
    check({name, "_row"}, 32'(pix_row), 0);
    check({name, "_col"}, 32'(pix_col), 0);
    check({name, "_last_col"}, 32'(pix_last_col), 0);
    check({name, "_last_frame"}, 32'(pix_last_frame), 0);
    check({name, "_busy"}, 32'(busy), 0);
    check({name, "_done"}, 32'(done), 0);
    check({name, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({name, "_fifo_count"}, 32'(dbg_fifo_count), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    int r_cyc;
    ifmap_bram_ready = 1'b1;
    ready_val = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);

    // T1: full-rate frame with exact timing.
    start_frame();
    @(negedge clock);
    check("t1_addr_c1", 32'(ifmap_read_addr), 0);
    check("t1_busy_c1", 32'(busy), 1);
    check("t1_valid_c1", 32'(pix_valid), 0);
    wait_done(1000, "t1");
    check("t1_first_beat_cycle", 32'(first_cyc - s_cyc), 2);
    check("t1_last_beat_cycle", 32'(last_cyc - s_cyc), 785);
    check("t1_done_cycle", 32'(done_cyc - s_cyc), 786);
    check("t1_beats", 32'(beats), 784);
    check("t1_busy_at_done", 32'(busy), 1);
    check("t1_addr_at_done", 32'(ifmap_read_addr), 0);
    @(negedge clock);
    check("t1_busy_after", 32'(busy), 0);
    check("t1_done_after", 32'(done), 0);
    check("t1_queue_empty", 32'(exp_q.size()), 0);

    // T2: random backpressure.
    rnd_ready = 1'b1;
    start_frame();
    wait_done(5000, "t2");
    rnd_ready = 1'b0;
    check("t2_beats", 32'(beats), 784);
    check("t2_queue_empty", 32'(exp_q.size()), 0);

    // T3: sink stalled for 100 cycles from start.
    ready_val = 1'b0;
    repeat (3) @(posedge clock);
    start_frame();
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (cyc - s_cyc == 1) begin
        check("t3_addr_c1", 32'(ifmap_read_addr), 0);
        check("t3_valid_c1", 32'(pix_valid), 0);
      end else begin
        check("t3_addr_hold", 32'(ifmap_read_addr), 1);
        check("t3_valid_hold", 32'(pix_valid), 1);
        check("t3_data_hold", 32'(pix_data), 0);
      end
    end
    ready_val = 1'b1;
    wait_done(1000, "t3");
    check("t3_beats", 32'(beats), 784);
    check("t3_queue_empty", 32'(exp_q.size()), 0);

    // T4: start while the BRAM is not yet filled.
    ifmap_bram_ready = 1'b0;
    start_frame();
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      check("t4_wait_addr", 32'(ifmap_read_addr), 0);
      check("t4_wait_valid", 32'(pix_valid), 0);
      check("t4_wait_state", 32'(dbg_state), 32'(ST_WAIT_BRAM));
    end
    @(posedge clock);
    #1;
    ifmap_bram_ready = 1'b1;
    r_cyc = cyc;
    wait_done(1000, "t4");
    check("t4_first_beat_cycle", 32'(first_cyc - r_cyc), 2);
    check("t4_done_cycle", 32'(done_cyc - r_cyc), 786);
    check("t4_beats", 32'(beats), 784);

    // T5: start mid-pass is ignored; start after done repeats the frame.
    d0 = done_cnt;
    start_frame();
    wait_beats(400, 1000, "t5");
    @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(1000, "t5");
    repeat (20) @(negedge clock);
    #2;
    check("t5_single_done", 32'(done_cnt - d0), 1);
    check("t5_beats", 32'(beats), 784);
    check("t5_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    start_frame();
    wait_done(1000, "t5b");
    check("t5b_first_beat_cycle", 32'(first_cyc - s_cyc), 2);
    check("t5b_done_cycle", 32'(done_cyc - s_cyc), 786);
    check("t5b_beats", 32'(beats), 784);

    // T6: asynchronous reset mid-pass, then a clean restart.
    start_frame();
    wait_beats(300, 1000, "t6");
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    beats = 0;
    d0 = done_cnt;
    repeat (30) @(negedge clock);
    #2;
    check("t6_no_beats_idle", 32'(beats), 0);
    check("t6_no_done_idle", 32'(done_cnt - d0), 0);
    start_frame();
    wait_done(1000, "t6");
    check("t6_first_beat_cycle", 32'(first_cyc - s_cyc), 2);
    check("t6_done_cycle", 32'(done_cyc - s_cyc), 786);
    check("t6_beats", 32'(beats), 784);
    check("t6_queue_empty", 32'(exp_q.size()), 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifmap_stream_reader.md
# ifmap_stream_reader

Streams the 28×28 8-bit input feature map out of the UART-filled ifmap BRAM into the accelerator's ifmap datapath. It sits directly downstream of the UART receive stage. Once that stage reports the BRAM full, each `start` pulse makes this block drive the BRAM read address and emit all 784 pixels in raster order on a valid/ready stream, tagged with row/column position. The block absorbs the BRAM's 1-cycle read latency and downstream backpressure with no dropped or duplicated pixels.

## Interface
- `IMG_W`, default 28, image width in pixels
- `IMG_H`, default 28, image height in pixels
- `ADDR_W`, default 10, BRAM address width
- `DATA_W`, default 8, pixel width
- `clock`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset asserted); release is synchronous to `clock` upstream
- `ifmap_bram_ready`  in  1  level; BRAM holds a complete frame
- `start`  in  1  pulse; request one frame pass
- `ifmap_read_addr`  out  ADDR_W  BRAM read address
- `ifmap_bram_out`  in  DATA_W  BRAM read data, valid 1 cycle after address
- `pix_valid`  out  1  stream valid
- `pix_ready`  in  1  stream ready
- `pix_data`  out  DATA_W  pixel value
- `pix_row`  out  5  row index 0..IMG_H-1
- `pix_col`  out  5  column index 0..IMG_W-1
- `pix_last_col`  out  1  beat is column IMG_W-1
- `pix_last_frame`  out  1  beat is pixel IMG_W*IMG_H-1
- `busy`  out  1  pass in progress
- `done`  out  1  1-cycle pulse when a pass completes

## Operation
- FSM states: IDLE, WAIT_BRAM, STREAM, DRAIN.
- IDLE: on `start` with `ifmap_bram_ready`=1, go to STREAM. On `start` with `ifmap_bram_ready`=0, go to WAIT_BRAM.
- WAIT_BRAM: go to STREAM on the first cycle `ifmap_bram_ready`=1.
- STREAM: issue addresses 0..783 in order. After issuing 783, go to DRAIN.
- DRAIN: stay until the last beat handshakes, then go to IDLE and pulse `done`.
- Read issue: a read is issued in a cycle only if (fifo_count + inflight − pop) < 2. pop = `pix_valid & pix_ready`; inflight is the read issued the previous cycle.
- Read data lands in a 2-entry output FIFO, so the block never holds more than 2 pixels.
- Row/col tags travel with each FIFO entry and are computed from the issued address by separate row/col counters, not by division. Col wraps 27→0 with row+1.
- `start` outside IDLE is ignored (no queuing).
- A handshake occurs only when `pix_valid & pix_ready`. While `pix_valid`=1 and `pix_ready`=0, all `pix_*` outputs hold stable.
- `ifmap_bram_ready` falling mid-pass is not a supported condition; the block does not check for it.

## Timing
- Reset values: `ifmap_read_addr`=0, `pix_valid`=0, `pix_data`=0, `pix_row`=0, `pix_col`=0, `pix_last_col`=0, `pix_last_frame`=0, `busy`=0, `done`=0, FSM=IDLE, FIFO empty.
- `start` in cycle 0 with BRAM ready: address 0 is driven in cycle 1 and `pix_valid` is first high in cycle 2.
- With `pix_ready` held at 1, throughput is 1 beat/cycle. Beats occupy cycles 2..785 and `done` pulses in cycle 786.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- WAIT_BRAM: address 0 is driven the cycle after `ifmap_bram_ready` is sampled high.
- `ifmap_read_addr` holds its last issued value when no read is issued, and returns to 0 on entering IDLE.
- Reset asserted mid-pass: all outputs take reset values immediately (asynchronous). The in-flight read is discarded, and no beat appears until a new `start`.

## Structure
- Shared package `ifmap_pkg` holds:
  - `IFMAP_W`=28, `IFMAP_H`=28, `IFMAP_PIXELS`=784, `IFMAP_ADDR_W`=10
  - the FSM state enum
- Sub-module `ifmap_skid_fifo` is a 2-entry FIFO with asynchronous active-low reset. Each entry is {data, row, col, last_col, last_frame}. Outputs are count, full and empty.

## Test plan
- BRAM model preloaded with mem[a]=a[7:0]; `ifmap_bram_ready`=1; `start` pulse; `pix_ready`=1 → exactly 784 beats in cycles 2..785 with data=a mod 256 and row=a/28, col=a%28. `pix_last_col` high at col 27; `pix_last_frame` high only on beat 783; `done` in cycle 786.
- Same setup, `pix_ready` randomized at 50% → 784 beats in order, none dropped or duplicated, outputs stable during stalls, FIFO count never above 2.
- `pix_ready`=0 for 100 cycles after `start` → only addresses 0 and 1 are issued, `ifmap_read_addr` holds at 1, `pix_data`=0 held. After release, the stream continues correctly.
- `start` with `ifmap_bram_ready`=0, then ready raised 50 cycles later → no address activity before that; address 0 is driven 1 cycle after ready is sampled; full frame follows.
- Second `start` at beat 400 → ignored, single `done`. `start` after `done` → identical second frame.
- `reset` driven low at beat 300 → outputs at reset values in the same cycle. After release with no `start`, no beats occur; a subsequent `start` streams a full 784-beat frame from address 0.
